// File: rtl/tlul_socket_1n.sv
// TL-UL 1:N demux socket: steers host A requests to one of N devices or an internal error responder.
// Latency: A and D paths are combinational (zero added cycles); error responses appear 1 cycle after accept.
// Backpressure: host a_ready follows the selected device; requests stall while switching devices or when full.
//
// Ports: clk_i/rst_i      clock, synchronous active-high reset
//        tl_h_i/tl_h_o    host-side request in, response out
//        tl_d_o/tl_d_i    per-device requests out, responses in
//        dev_select_i     target device index; any value >= N selects the error responder

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_socket_1n #(
  parameter int unsigned N              = 4,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned NWD           = $clog2(MaxOutstanding + 1),
  localparam int unsigned SELW          = $clog2(N + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_h_i,
  output tlul_pkg::tl_d2h_t tl_h_o,
  output tlul_pkg::tl_h2d_t tl_d_o [N],
  input  tlul_pkg::tl_d2h_t tl_d_i [N],
  input  logic [SELW-1:0]   dev_select_i
);

  logic [NWD-1:0]  cnt;
  logic [SELW-1:0] sel_q;
  logic            err_pend;
  logic [2:0]      err_opc;
  logic [7:0]      err_src;
  logic [1:0]      err_size;

  logic            cnt_nz;
  logic            sel_err;
  logic            q_err;
  logic            hold;
  logic            tgt_ready;
  logic            a_ready;
  logic            acc;
  logic            rsp;
  tlul_pkg::tl_d2h_t rsp_mux;

  assign cnt_nz  = (cnt != '0);
  assign sel_err = (dev_select_i >= SELW'(N));
  assign q_err   = (sel_q >= SELW'(N));

  // All outstanding requests share one destination, so responses return in
  // order without per-request tracking. Changing target waits for a drain.
  assign hold = (cnt_nz && (dev_select_i != sel_q)) ||
                (cnt == NWD'(MaxOutstanding));

  always_comb begin
    tgt_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (dev_select_i == SELW'(i)) tgt_ready = tl_d_i[i].a_ready;
    end
    if (sel_err) tgt_ready = !err_pend;
  end

  assign a_ready = !hold && tgt_ready;
  assign acc     = tl_h_i.a_valid && a_ready;
  assign rsp     = tl_h_o.d_valid && tl_h_i.d_ready;

  // Response source: the device that owns the outstanding requests, or the
  // internal error responder.
  always_comb begin
    rsp_mux = '0;
    if (cnt_nz) begin
      if (q_err) begin
        rsp_mux.d_valid  = err_pend;
        rsp_mux.d_opcode = (err_opc == tlul_pkg::Get) ? tlul_pkg::AccessAckData
                                                      : tlul_pkg::AccessAck;
        rsp_mux.d_size   = err_size;
        rsp_mux.d_source = err_src;
        rsp_mux.d_data   = '1;
        rsp_mux.d_error  = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (sel_q == SELW'(i)) rsp_mux = tl_d_i[i];
        end
      end
    end
  end

  always_comb begin
    tl_h_o         = rsp_mux;
    tl_h_o.a_ready = a_ready;
  end

  // A-channel payload broadcasts; only the handshake bits are per-device.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = tl_h_i.a_valid && !hold && (dev_select_i == SELW'(i));
      tl_d_o[i].d_ready = tl_h_i.d_ready && cnt_nz && (sel_q == SELW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      sel_q    <= '0;
      err_pend <= 1'b0;
      err_opc  <= '0;
      err_src  <= '0;
      err_size <= '0;
    end else begin
      if (acc && !rsp)      cnt <= cnt + NWD'(1);
      else if (rsp && !acc) cnt <= cnt - NWD'(1);

      if (acc) sel_q <= dev_select_i;

      // a_ready is low for the error target while a response is pending,
      // so set and clear never coincide.
      if (acc && sel_err) begin
        err_pend <= 1'b1;
        err_opc  <= tl_h_i.a_opcode;
        err_src  <= tl_h_i.a_source;
        err_size <= tl_h_i.a_size;
      end else if (rsp && q_err) begin
        err_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tlul_socket_1n.sv
// Testbench for tlul_socket_1n: directed scenarios followed by random traffic.
// Reference model keeps a queue of in-flight requests; expectations derive from it.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_tlul_socket_1n;

  localparam int N    = 4;
  localparam int MAXO = 3;
  localparam int SELW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst;
  tlul_pkg::tl_h2d_t tl_h_i;
  tlul_pkg::tl_d2h_t tl_h_o;
  tlul_pkg::tl_h2d_t tl_d_o [N];
  tlul_pkg::tl_d2h_t tl_d_i [N];
  logic [SELW-1:0]   dev_sel;

  always #5 clk = ~clk;

  tlul_socket_1n #(.N(N), .MaxOutstanding(MAXO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tl_h_i       (tl_h_i),
    .tl_h_o       (tl_h_o),
    .tl_d_o       (tl_d_o),
    .tl_d_i       (tl_d_i),
    .dev_select_i (dev_sel)
  );

  typedef struct {
    int         dest;
    logic [2:0] opc;
    logic [7:0] src;
    logic [1:0] size;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    tl_h_i           = '0;
    tl_h_i.a_address = $urandom;
    tl_h_i.a_data    = $urandom;
    dev_sel          = '0;
    for (int i = 0; i < N; i++) begin
      tl_d_i[i]          = '0;
      tl_d_i[i].a_ready  = 1'b1;
      tl_d_i[i].d_data   = $urandom;
      tl_d_i[i].d_source = 8'($urandom);
      tl_d_i[i].d_opcode = tlul_pkg::AccessAckData;
    end
  endtask

  task automatic req(input int sel, input logic [2:0] opc, input logic [7:0] src, input logic [1:0] size);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = opc;
    tl_h_i.a_source  = src;
    tl_h_i.a_size    = size;
    tl_h_i.a_address = $urandom;
    dev_sel          = SELW'(sel);
  endtask

  task automatic rand_inputs();
    logic [2:0] opcs [3];
    opcs[0] = tlul_pkg::PutFullData;
    opcs[1] = tlul_pkg::PutPartialData;
    opcs[2] = tlul_pkg::Get;
    rst              = ($urandom_range(0, 63) == 0);
    tl_h_i           = '0;
    tl_h_i.a_valid   = ($urandom_range(0, 9) < 6);
    tl_h_i.a_opcode  = opcs[$urandom_range(0, 2)];
    tl_h_i.a_source  = 8'($urandom);
    tl_h_i.a_size    = 2'($urandom_range(0, 2));
    tl_h_i.a_address = $urandom;
    tl_h_i.a_data    = $urandom;
    tl_h_i.a_mask    = 4'($urandom);
    tl_h_i.d_ready   = ($urandom_range(0, 9) < 7);
    dev_sel          = SELW'($urandom_range(0, N + 1));
    for (int i = 0; i < N; i++) begin
      tl_d_i[i]          = '0;
      tl_d_i[i].a_ready  = ($urandom_range(0, 9) < 7);
      tl_d_i[i].d_valid  = ($urandom_range(0, 1) == 1);
      tl_d_i[i].d_opcode = 3'($urandom_range(0, 1));
      tl_d_i[i].d_size   = 2'($urandom);
      tl_d_i[i].d_source = 8'($urandom);
      tl_d_i[i].d_data   = $urandom;
      tl_d_i[i].d_error  = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Check outputs for the current inputs, then advance the model by one clock.
  task automatic step();
    int         qn, dest, sel, bc;
    logic       allowed, exp_ardy, exp_dvld, acc, rsp;
    logic [N-1:0] exp_avld, exp_drdy, got_avld, got_drdy;
    ent_t       e;
    #4;
    qn   = q.size();
    dest = (qn > 0) ? q[0].dest : 0;
    sel  = int'(dev_sel);
    allowed = (qn == 0) || ((sel == dest) && (qn < MAXO));
    if (sel < N) exp_ardy = allowed && tl_d_i[sel].a_ready;
    else         exp_ardy = allowed && (qn == 0);
    for (int i = 0; i < N; i++) begin
      exp_avld[i] = allowed && tl_h_i.a_valid && (sel == i);
      exp_drdy[i] = (qn > 0) && (dest == i) && tl_h_i.d_ready;
      got_avld[i] = tl_d_o[i].a_valid;
      got_drdy[i] = tl_d_o[i].d_ready;
    end
    exp_dvld = (qn > 0) && ((dest < N) ? tl_d_i[dest].d_valid : 1'b1);

    chk("outstanding", 64'(dut.cnt), 64'(qn));
    chk("h_a_ready", 64'(tl_h_o.a_ready), 64'(exp_ardy));
    chk("d_a_valid", 64'(got_avld), 64'(exp_avld));
    chk("d_d_ready", 64'(got_drdy), 64'(exp_drdy));
    chk("h_d_valid", 64'(tl_h_o.d_valid), 64'(exp_dvld));
    if (exp_dvld) begin
      if (dest < N) begin
        chk("fwd_data", 64'(tl_h_o.d_data), 64'(tl_d_i[dest].d_data));
        chk("fwd_source", 64'(tl_h_o.d_source), 64'(tl_d_i[dest].d_source));
        chk("fwd_opcode", 64'(tl_h_o.d_opcode), 64'(tl_d_i[dest].d_opcode));
        chk("fwd_error", 64'(tl_h_o.d_error), 64'(tl_d_i[dest].d_error));
      end else begin
        chk("err_opcode", 64'(tl_h_o.d_opcode), (q[0].opc == 3'h4) ? 64'd1 : 64'd0);
        chk("err_error", 64'(tl_h_o.d_error), 64'd1);
        chk("err_data", 64'(tl_h_o.d_data), 64'hFFFF_FFFF);
        chk("err_source", 64'(tl_h_o.d_source), 64'(q[0].src));
        chk("err_size", 64'(tl_h_o.d_size), 64'(q[0].size));
        chk("err_param", 64'(tl_h_o.d_param), 64'd0);
      end
    end
    bc = $urandom_range(0, N - 1);
    chk("bcast_addr", 64'(tl_d_o[bc].a_address), 64'(tl_h_i.a_address));
    chk("bcast_source", 64'(tl_d_o[bc].a_source), 64'(tl_h_i.a_source));

    acc = tl_h_i.a_valid && exp_ardy;
    rsp = exp_dvld && tl_h_i.d_ready;
    if (rst) begin
      q.delete();
    end else begin
      if (rsp) void'(q.pop_front());
      if (acc) begin
        e.dest = sel;
        e.opc  = tl_h_i.a_opcode;
        e.src  = tl_h_i.a_source;
        e.size = tl_h_i.a_size;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < N; i++) tl_d_i[i].d_valid = 1'b1;
    @(posedge clk);
    #1;
    // Reset and idle with devices pushing stray responses.
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Three Gets to device 2, then three in-order responses.
    idle();
    req(2, tlul_pkg::Get, 8'h11, 2'd2);
    repeat (3) step();
    tl_h_i.a_valid    = 1'b0;
    tl_h_i.d_ready    = 1'b1;
    tl_d_i[2].d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tl_d_i[2].d_source = 8'(8'h20 + k);
      tl_d_i[2].d_data   = $urandom;
      step();
    end
    step();

    // Device switch waits for the outstanding device-1 request to drain.
    idle();
    req(1, tlul_pkg::Get, 8'h01, 2'd2);
    step();
    req(3, tlul_pkg::PutFullData, 8'h03, 2'd2);
    step();
    step();
    tl_d_i[1].d_valid = 1'b1;
    tl_h_i.d_ready    = 1'b1;
    step();
    tl_d_i[1].d_valid = 1'b0;
    step();
    tl_h_i.a_valid    = 1'b0;
    tl_d_i[3].d_valid = 1'b1;
    step();
    idle();
    step();

    // Outstanding limit on device 0.
    idle();
    req(0, tlul_pkg::Get, 8'h40, 2'd1);
    repeat (5) step();
    tl_h_i.d_ready    = 1'b1;
    tl_d_i[0].d_valid = 1'b1;
    step();
    tl_d_i[0].d_valid = 1'b0;
    step();
    tl_h_i.a_valid    = 1'b0;
    tl_d_i[0].d_valid = 1'b1;
    repeat (4) step();

    // Error responder: Get.
    idle();
    req(4, tlul_pkg::Get, 8'h05, 2'd2);
    step();
    tl_h_i.a_valid = 1'b0;
    tl_h_i.d_ready = 1'b1;
    step();
    step();

    // Error responder: PutFullData under host back-pressure, second request stalled.
    idle();
    req(4, tlul_pkg::PutFullData, 8'h33, 2'd2);
    step();
    tl_h_i.d_ready = 1'b0;
    repeat (3) step();
    tl_h_i.d_ready = 1'b1;
    step();
    step();
    tl_h_i.a_valid = 1'b0;
    step();
    idle();
    step();

    // Mid-operation reset with late responses.
    idle();
    req(1, tlul_pkg::Get, 8'h77, 2'd2);
    step();
    step();
    rst = 1'b1;
    tl_h_i.a_valid = 1'b0;
    step();
    rst = 1'b0;
    tl_h_i.d_ready    = 1'b1;
    tl_d_i[1].d_valid = 1'b1;
    step();
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
